// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction-fetch unit.
// Owns the architectural PC, fetches one word per instruction over a
// request/ready handshake and hands it to decode over valid/ready.
// Optional feature macro: IFU_ALIGN_CHECK_EN, which traps a misaligned PC into a
// terminal error state. When the macro is undefined, the low PC bits are masked
// off the memory address and fetch_err is tied low.
//
// state  | meaning
// S_IDLE | just out of reset, all outputs inactive
// S_REQ  | fetch request outstanding at imem_addr
// S_OUT  | instruction held for decode, waiting for id_ready
// S_ERR  | misaligned PC trapped (alignment check build only), left by rst
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        id_ready,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic [31:0] npc_in,
    output logic [31:0] fetch_cnt,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_OUT  = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic        imem_req_q, imem_req_d;
    logic        if_valid_q, if_valid_d;
    logic        pc_bad_q, pc_bad_d;

`ifdef IFU_ALIGN_CHECK_EN
    logic fetch_err_q, fetch_err_d;

    assign pc_bad_q  = (pc_q[1:0] != 2'b00);
    assign pc_bad_d  = (pc_d[1:0] != 2'b00);
    assign imem_addr = pc_q;
    assign fetch_err = fetch_err_q;

    // Error flag is sticky once the trap state is reached.
    always_comb begin
        fetch_err_d = fetch_err_q | (state_d == S_ERR);
    end

    // Error flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_err_q <= 1'b0;
        end else begin
            fetch_err_q <= fetch_err_d;
        end
    end
`else
    assign pc_bad_q  = 1'b0;
    assign pc_bad_d  = 1'b0;
    assign imem_addr = {pc_q[31:2], 2'b00};
    assign fetch_err = 1'b0;
`endif

    assign imem_req  = imem_req_q;
    assign if_valid  = if_valid_q;
    assign instr     = instr_q;
    assign pc        = pc_q;
    assign fetch_cnt = fetch_cnt_q;
    assign pc_plus4  = pc_q + 32'd4;

    // Next-state and datapath updates; registered outputs follow the next state
    // so imem_req/if_valid are valid in the same cycle the state is.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        fetch_cnt_d = fetch_cnt_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (pc_bad_q) begin
                    state_d = S_ERR;
                end else if (imem_rdy) begin
                    instr_d = imem_rdata;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (id_ready) begin
                    pc_d        = npc_in;
                    fetch_cnt_d = fetch_cnt_q + 32'd1;
                    state_d     = S_REQ;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // A misaligned PC entering S_REQ never raises the request.
        imem_req_d = (state_d == S_REQ) && !pc_bad_d;
        if_valid_d = (state_d == S_OUT);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            instr_q     <= 32'd0;
            fetch_cnt_q <= 32'd0;
            imem_req_q  <= 1'b0;
            if_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            fetch_cnt_q <= fetch_cnt_d;
            imem_req_q  <= imem_req_d;
            if_valid_q  <= if_valid_d;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed table, corner-case sequences and random traffic
// against a transaction-level reference model of the fetch unit.
module tb_ifu_fetch;

`ifdef IFU_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif
    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rdy = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        if_valid;
    logic        id_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] npc_in = 32'd0;
    logic [31:0] fetch_cnt;
    logic        fetch_err;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model: started = past the idle cycle, have = instruction held
    bit          m_started, m_have, m_err;
    logic [31:0] m_pc, m_instr, m_cnt;

    ifu_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdy(imem_rdy), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .id_ready(id_ready),
        .instr(instr), .pc(pc), .pc_plus4(pc_plus4),
        .npc_in(npc_in), .fetch_cnt(fetch_cnt), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit m_misaligned();
        return ALIGN_EN && (m_pc[1:0] != 2'b00);
    endfunction

    task automatic model_update();
        if (rst) begin
            m_started = 0; m_have = 0; m_err = 0;
            m_pc = RESET_PC; m_instr = 0; m_cnt = 0;
        end else if (!m_started) begin
            m_started = 1;
        end else if (m_err) begin
        end else if (m_have) begin
            if (id_ready) begin
                m_pc = npc_in; m_cnt = m_cnt + 1; m_have = 0;
            end
        end else if (m_misaligned()) begin
            m_err = 1;
        end else if (imem_rdy) begin
            m_instr = imem_rdata; m_have = 1;
        end
    endtask

    task automatic check_model();
        chk("m_req",   {31'd0, imem_req}, {31'd0, m_started && !m_have && !m_err && !m_misaligned()});
        chk("m_addr",  imem_addr, ALIGN_EN ? m_pc : {m_pc[31:2], 2'b00});
        chk("m_valid", {31'd0, if_valid}, {31'd0, m_have});
        chk("m_instr", instr, m_instr);
        chk("m_pc",    pc, m_pc);
        chk("m_pc4",   pc_plus4, m_pc + 32'd4);
        chk("m_cnt",   fetch_cnt, m_cnt);
        chk("m_err",   {31'd0, fetch_err}, {31'd0, m_err});
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_model();
    endtask

    task automatic drive(input logic r, input logic rdy, input logic [31:0] rd,
                         input logic rdy_id, input logic [31:0] npc);
        rst = r; imem_rdy = rdy; imem_rdata = rd; id_ready = rdy_id; npc_in = npc;
    endtask

    typedef struct {
        logic        rst, rdy;
        logic [31:0] rdata;
        logic        rdy_id;
        logic [31:0] npc;
        logic        e_req, e_valid;
        logic [31:0] e_addr, e_instr, e_cnt;
    } vec_t;

    vec_t vt[10];

    initial begin
        logic [31:0] hold_instr, hold_pc;
        vt[0] = '{1, 0, 32'h0, 0, 32'h0,      0, 0, 32'h3000, 32'h0, 0};
        vt[1] = '{1, 1, 32'h5, 1, 32'h0,      0, 0, 32'h3000, 32'h0, 0};
        vt[2] = '{1, 0, 32'h0, 0, 32'h0,      0, 0, 32'h3000, 32'h0, 0};
        vt[3] = '{0, 0, 32'h0, 1, 32'h4000,   1, 0, 32'h3000, 32'h0, 0};
        vt[4] = '{0, 1, 32'hAAAA_0001, 0, 0,  0, 1, 32'h3000, 32'hAAAA_0001, 0};
        vt[5] = '{0, 0, 32'h0, 1, 32'h3004,   1, 0, 32'h3004, 32'hAAAA_0001, 1};
        vt[6] = '{0, 1, 32'hBBBB_0002, 1, 0,  0, 1, 32'h3004, 32'hBBBB_0002, 1};
        vt[7] = '{0, 1, 32'h0, 1, 32'h3008,   1, 0, 32'h3008, 32'hBBBB_0002, 2};
        vt[8] = '{0, 1, 32'hCCCC_0003, 1, 0,  0, 1, 32'h3008, 32'hCCCC_0003, 2};
        vt[9] = '{0, 0, 32'h0, 1, 32'h300C,   1, 0, 32'h300C, 32'hCCCC_0003, 3};

        // reset and back-to-back fetch
        for (int i = 0; i < 10; i++) begin
            drive(vt[i].rst, vt[i].rdy, vt[i].rdata, vt[i].rdy_id, vt[i].npc);
            step();
            chk("t_req",   {31'd0, imem_req}, {31'd0, vt[i].e_req});
            chk("t_valid", {31'd0, if_valid}, {31'd0, vt[i].e_valid});
            chk("t_addr",  imem_addr, vt[i].e_addr);
            chk("t_instr", instr, vt[i].e_instr);
            chk("t_cnt",   fetch_cnt, vt[i].e_cnt);
        end

        // backpressure: decode stalls 5 cycles
        drive(0, 1, 32'h1000_0003, 0, 32'h0);
        step();
        hold_instr = instr; hold_pc = pc;
        chk("bp_instr0", hold_instr, 32'h1000_0003);
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, $urandom, 0, $urandom);
            step();
            chk("bp_instr", instr, 32'h1000_0003);
            chk("bp_pc",    pc, 32'h300C);
            chk("bp_req",   {31'd0, imem_req}, 32'd0);
            chk("bp_valid", {31'd0, if_valid}, 32'd1);
        end
        drive(0, 0, 32'h0, 1, 32'h3020);
        step();
        chk("bp_cnt1", fetch_cnt, 32'd4);
        drive(0, 0, 32'h0, 1, 32'h5555_0000);
        step();
        chk("bp_cnt2", fetch_cnt, 32'd4);
        chk("bp_addr", imem_addr, 32'h3020);

        // memory wait then branch
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, $urandom, 1, $urandom);
            step();
            chk("mw_addr", imem_addr, 32'h3020);
            chk("mw_req",  {31'd0, imem_req}, 32'd1);
        end
        drive(0, 1, 32'h1234_5678, 0, 32'h0);
        step();
        drive(0, 0, 32'h0, 1, 32'h3010);
        step();
        chk("br_addr", imem_addr, 32'h3010);
        chk("br_req",  {31'd0, imem_req}, 32'd1);

        // reset mid-request with imem_rdy high
        drive(1, 1, 32'hDEAD_BEEF, 1, 32'h0);
        step();
        chk("rs_instr", instr, 32'd0);
        chk("rs_pc",    pc, RESET_PC);
        chk("rs_cnt",   fetch_cnt, 32'd0);
        chk("rs_req",   {31'd0, imem_req}, 32'd0);
        drive(0, 0, 32'h0, 0, 32'h0);
        step();
        chk("rs_req2",  {31'd0, imem_req}, 32'd1);

        // misaligned PC
        drive(0, 1, 32'h0BAD_0001, 0, 32'h0);
        step();
        drive(0, 0, 32'h0, 1, 32'h3006);
        step();
        chk("ma_addr", imem_addr, ALIGN_EN ? 32'h3006 : 32'h3004);
        chk("ma_req",  {31'd0, imem_req}, ALIGN_EN ? 32'd0 : 32'd1);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 32'h0BAD_0002, 0, 32'h0);
            step();
        end
        chk("ma_err", {31'd0, fetch_err}, ALIGN_EN ? 32'd1 : 32'd0);
        chk("ma_pc",  pc, 32'h3006);
        if (ALIGN_EN) chk("ma_req2", {31'd0, imem_req}, 32'd0);
        drive(1, 0, 32'h0, 0, 32'h0);
        step();

        // random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] npc;
            int sel;
            sel = $urandom_range(99);
            if (sel < 70)      npc = m_pc + 32'd4;
            else if (sel < 97) npc = $urandom & 32'hFFFF_FFFC;
            else               npc = $urandom;
            if (i % 300 == 5)  npc = 32'hFFFF_FFFC;
            drive(($urandom_range(63) == 0), $urandom_range(1), $urandom,
                  $urandom_range(1), npc);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction-fetch unit for the multi-cycle MIPS microsystem. It owns the architectural PC register and fetches one word per instruction from instruction memory over a request/ready handshake. It presents the fetched instruction to decode with a valid/ready handshake and exports `pc_plus4`, the "present instruction + 4" value the next-PC unit consumes. When decode accepts, it loads the next-PC unit's result `npc_in` as the new PC.

## Interface
- `RESET_PC`, 32'h0000_3000, PC value loaded on reset.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `imem_req`  output  1  fetch request; address valid while high.
- `imem_addr`  output  32  word address to instruction memory (equals `pc`).
- `imem_rdy`  input  1  memory has `imem_rdata` valid this cycle.
- `imem_rdata`  input  32  instruction word.
- `if_valid`  output  1  `instr` and `pc` hold a fetched instruction.
- `id_ready`  input  1  decode accepts the instruction this cycle.
- `instr`  output  32  instruction register.
- `pc`  output  32  address of the instruction in `instr`.
- `pc_plus4`  output  32  `pc + 4`, fed to the next-PC unit's `pc` input.
- `npc_in`  input  32  next PC from the next-PC unit; sampled on acceptance.
- `fetch_cnt`  output  32  count of instructions accepted by decode.
- `fetch_err`  output  1  misaligned-PC error flag (see Configuration).

## Operation
- States: `S_IDLE`, `S_REQ`, `S_OUT`, `S_ERR`.
- **S_IDLE:** entered on reset; all outputs are inactive. The unit moves to `S_REQ` on the next cycle unconditionally.
- **S_REQ:** `imem_req`=1 and `imem_addr`=`pc`.
  - On `imem_rdy`=1: `instr` <= `imem_rdata`, then go to `S_OUT`.
  - Otherwise: hold the request with the address stable.
- **S_OUT:** `if_valid`=1.
  - On `id_ready`=1: `pc` <= `npc_in`, `fetch_cnt` += 1, then go to `S_REQ`.
  - Otherwise: hold `instr` and `pc` stable.
- **S_ERR:** terminal; only reset leaves it.
- `pc_plus4` = `pc + 4`, combinational, 32-bit modulo: 32'hFFFF_FFFC gives 0.
- `npc_in` is only sampled in `S_OUT` with `id_ready`=1; its value at any other time is ignored.
- `imem_rdy` outside `S_REQ` is ignored. `id_ready` outside `S_OUT` is ignored.
- `fetch_cnt` wraps from 32'hFFFF_FFFF to 0.
- Reset values: `pc`=`RESET_PC`, `instr`=0, `fetch_cnt`=0, `imem_req`=0, `if_valid`=0, `fetch_err`=0, state=`S_IDLE`.

## Timing
- Minimum instruction period is 2 cycles: `S_REQ` with `imem_rdy` at cycle N, then `S_OUT` with `id_ready` at cycle N+1.
- `instr` becomes valid the cycle after `imem_rdy` is sampled.
- The new PC appears on `imem_addr` the cycle after acceptance.
- First `imem_req` is asserted 2 cycles after the reset-high edge: one edge to `S_IDLE`, one edge to `S_REQ`.
- `rst` asserted in any state, mid-request or mid-handshake, wins at the next edge. An outstanding `imem_rdy` in that same cycle is dropped.
- All outputs except `pc_plus4` and `imem_addr` are registered. `imem_addr` is a direct copy of the `pc` register.

## Configuration
- **`IFU_ALIGN_CHECK_EN` defined:**
  - On entry to `S_REQ` with `pc[1:0]` != 0, `imem_req` stays 0 and the next state is `S_ERR`.
  - `fetch_err` sets to 1 and stays 1 until `rst`.
  - `pc` holds the faulting address.
- **`IFU_ALIGN_CHECK_EN` undefined:**
  - No alignment check; `S_ERR` is unreachable.
  - `fetch_err` is tied to 0.
  - `imem_addr` is {`pc[31:2]`, 2'b00}.

## Test plan
- **Reset:** hold `rst` 3 cycles, then release -> `imem_req`=0 for the first cycle after release, then `imem_req`=1 with `imem_addr`=32'h0000_3000, `fetch_cnt`=0.
- **Back-to-back fetch:** `imem_rdy` and `id_ready` always 1, `npc_in`=`pc_plus4` -> PCs 3000, 3004, 3008 each 2 cycles apart; `fetch_cnt`=3 after three acceptances.
- **Backpressure:** `id_ready`=0 for 5 cycles after `if_valid`, `imem_rdata`=32'h1000_0003 -> `instr` and `pc` stable for all 5 cycles; no `imem_req` during that time; exactly one acceptance.
- **Memory wait and branch:** `imem_rdy` delayed 4 cycles, then `npc_in`=32'h0000_3010 on acceptance -> `imem_addr` stable during the wait, next `imem_addr`=32'h0000_3010.
- **Reset mid-fetch:** `rst` pulsed while in `S_REQ` with `imem_rdy`=1 -> `instr` stays 0, `pc`=32'h0000_3000, `fetch_cnt`=0.
- **Misaligned PC (macro on):** `npc_in`=32'h0000_3006 -> `fetch_err`=1, `imem_req` never asserted again, `pc`=32'h0000_3006 until reset.
- **Misaligned PC (macro off):** same stimulus -> `imem_addr`=32'h0000_3004, `fetch_err`=0.
